bar_reg_bridge: RTL
===================

Name: bar_reg_bridge

Overview:
- AXI4-Lite slave that converts one 32-bit BAR port into a simple strobe/ack register bus for the control register banks.
- Sits directly downstream of the PCIe wrapper's 32-bit BAR output (bar0/bar1/bar2), with one instance per BAR.
- Handles at most one outstanding transaction.
- Provides address decode-range checking, arbitration between reads and writes, and a timeout so that a dead register bank can never hang the host.

Parameters:
- AW, 32: AXI address width.
- DW, 32: data width. Only 32 is supported.
- REG_AW, 12: byte-address bits decoded. The window size is 2**REG_AW bytes.
- TIMEOUT, 255: maximum number of cycles to wait for reg_ack after a strobe. Range 1..65535.

Ports:
- bar_clk  in  1  clock.
- bar_rst  in  1  synchronous reset, active-high.
- s  axi4_lite_if.s  -  AXI4-Lite slave port (AW/W/B/AR/R channels, DW/AW as parameters).
- reg_addr  out  REG_AW-2  word address (byte addr[REG_AW-1:2]).
- reg_wr  out  1  write strobe, one-cycle pulse.
- reg_rd  out  1  read strobe, one-cycle pulse.
- reg_wdata  out  32  write data.
- reg_wstrb  out  4  byte enables.
- reg_rdata  in  32  read data, valid with reg_ack.
- reg_ack  in  1  access complete.
- reg_err  in  1  slave error, qualified by reg_ack.

Behaviour:
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata 0; reg_* outputs 0; FSM in IDLE; timeout counter 0; arbitration flag = write-priority.
- FSM states and transitions:
  - IDLE: awready=wready=arready=1, except that a channel already captured deasserts its own ready. AW and W are captured independently, in any order and any gap. A write becomes pending once both have been captured. AR is captured when arvalid is high.
  - Arbitration: if a complete write and an AR become available in the same cycle, grant alternates using a last-granted flag, and only the granted channel's ready is high that cycle. Otherwise first-come.
  - Decode: if addr[AW-1:REG_AW] != 0, go straight to RESP with resp=2'b11 (DECERR) and rdata=0. No strobe is issued.
  - WR_REQ / RD_REQ: reg_wr or reg_rd is high for exactly the first cycle. reg_addr, reg_wdata and reg_wstrb are held stable until the state exits. reg_ack is sampled from the strobe cycle onward, so an ack in the same cycle counts.
  - On ack: resp = reg_err ? 2'b10 : 2'b00. For reads, rdata = reg_rdata.
  - On timeout: when the counter reaches TIMEOUT without ack, resp=2'b10 and, for reads, rdata=32'hDEAD_BEEF. A late reg_ack arriving after timeout is ignored.
  - WR_RESP / RD_RESP: bvalid or rvalid held high until the matching ready. On handshake, return to IDLE. No new AW/W/AR is accepted while a response is pending.
- Latency: requests accepted in cycle N → strobe in N+1 → ack in N+1 at the earliest → bvalid/rvalid in N+2.
- wstrb==0 still issues a write access with reg_wstrb=0.
- arprot and awprot are ignored.
- Reset mid-transaction drops the pending access and any captured AW/W, clears the counter, and returns to IDLE. No response is issued.

Decomposition:
- Package bar_reg_pkg holds:
  - state enum: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP;
  - resp constants: RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Single flat module; no sub-module is warranted. The timeout counter is inline with width $clog2(TIMEOUT+1).

Test Plan:
1. Write:
   - Stimulus: AW=0x10 and W=0xA5A5_0001 (wstrb 4'hF) in the same cycle; reg_ack one cycle after the strobe.
   - Response: reg_addr=4, reg_wr pulses once, bresp=00; bvalid two cycles after the strobe.
2. W before AW: W presented 3 cycles before AW=0x20. Response: wready drops after W is captured; the write is issued only once AW arrives; bresp=00.
3. Read, bank silent: AR=0x08 with no reg_ack. Response: rvalid exactly TIMEOUT cycles after the strobe, rresp=10, rdata=0xDEAD_BEEF. A late ack is ignored.
4. Decode error: AR=0x1000 with REG_AW=12. Response: no reg_rd, rresp=11, rdata=0.
5. Simultaneous requests and backpressure:
   - Stimulus: complete write and AR valid in the same cycle, twice in a row; bready held low for 10 cycles.
   - Response: the grants alternate (write first after reset); bvalid stays high; arready stays 0 until the B handshake.
6. Reset mid-operation: assert bar_rst in the cycle after reg_rd. Response: all outputs return to 0; a later reg_ack causes no response; the next transaction behaves normally.

Source files
------------

// File: rtl/bar_reg_bridge_pkg.sv
// Shared types and constants for the BAR-to-register-bus bridge.
package bar_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        WR_RESP,
        RD_RESP
    } state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // AXI response for a completed register-bus access.
    function automatic logic [1:0] ack_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/bar_reg_bridge_if.sv
// AXI4-Lite bundle; modport s faces the bridge, modport m faces the host side.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport s (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport m (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/bar_reg_bridge.sv
// AXI4-Lite slave that turns one BAR window into a strobe/ack register bus.
// One access in flight; out-of-window addresses answer DECERR without a strobe;
// a bank that never acks is answered with SLVERR after TIMEOUT cycles.
module bar_reg_bridge
    import bar_reg_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int REG_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              bar_clk,
    input  logic              bar_rst,
    axi4_lite_if.s            s,
    output logic [REG_AW-3:0] reg_addr,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_wstrb,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_ack,
    input  logic              reg_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              aw_have_q, aw_have_d;
    logic              w_have_q, w_have_d;
    logic [AW-1:2]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic [REG_AW-3:0] addr_q, addr_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rd_stb_q, rd_stb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              prio_wr_q, prio_wr_d;   // 1: write wins the next tie

    logic              aw_rdy, w_rdy, ar_rdy;
    logic [AW-1:2]     wr_addr;
    logic              wr_avail, tie, grant_wr, grant_rd;
    logic [CNT_W-1:0]  cnt_inc;

    assign wr_addr  = aw_have_q ? awaddr_q : s.awaddr[AW-1:2];
    assign wr_avail = (aw_have_q | s.awvalid) & (w_have_q | s.wvalid);
    assign tie      = wr_avail & s.arvalid;
    assign grant_wr = wr_avail & (~s.arvalid | prio_wr_q);
    assign grant_rd = s.arvalid & (~wr_avail | ~prio_wr_q);
    assign cnt_inc  = cnt_q + 1'b1;

    // Next-state, capture, arbitration and response generation.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        cnt_d     = cnt_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        prio_wr_d = prio_wr_q;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        ar_rdy    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bar_rst) begin
                    // On a tie only the winner's channel shows ready.
                    aw_rdy = ~aw_have_q & ~(tie & ~prio_wr_q);
                    w_rdy  = ~w_have_q & ~(tie & ~prio_wr_q);
                    ar_rdy = ~(tie & prio_wr_q);

                    if (s.awvalid && aw_rdy) begin
                        aw_have_d = 1'b1;
                        awaddr_d  = s.awaddr[AW-1:2];
                    end
                    if (s.wvalid && w_rdy) begin
                        w_have_d = 1'b1;
                        wdata_d  = s.wdata;
                        wstrb_d  = s.wstrb;
                    end

                    if (grant_wr) begin
                        aw_have_d = 1'b0;
                        w_have_d  = 1'b0;
                        prio_wr_d = 1'b0;
                        addr_d    = wr_addr[REG_AW-1:2];
                        if (|wr_addr[AW-1:REG_AW]) begin
                            bresp_d = RESP_DECERR;
                            state_d = WR_RESP;
                        end else begin
                            wr_stb_d = 1'b1;
                            state_d  = WR_REQ;
                        end
                    end else if (grant_rd) begin
                        prio_wr_d = 1'b1;
                        addr_d    = s.araddr[REG_AW-1:2];
                        if (|s.araddr[AW-1:REG_AW]) begin
                            rresp_d = RESP_DECERR;
                            rdata_d = '0;
                            state_d = RD_RESP;
                        end else begin
                            rd_stb_d = 1'b1;
                            state_d  = RD_REQ;
                        end
                    end
                end
            end

            WR_REQ, RD_REQ: begin
                if (reg_ack) begin
                    cnt_d = '0;
                    if (state_q == RD_REQ) begin
                        rresp_d = ack_resp(reg_err);
                        rdata_d = reg_rdata;
                        state_d = RD_RESP;
                    end else begin
                        bresp_d = ack_resp(reg_err);
                        state_d = WR_RESP;
                    end
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    cnt_d = '0;
                    if (state_q == RD_REQ) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = TIMEOUT_RDATA;
                        state_d = RD_RESP;
                    end else begin
                        bresp_d = RESP_SLVERR;
                        state_d = WR_RESP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            WR_RESP: if (s.bready) state_d = IDLE;
            RD_RESP: if (s.rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge bar_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (bar_rst) begin
            state_q   <= IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            cnt_q     <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            prio_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            cnt_q     <= cnt_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            prio_wr_q <= prio_wr_d;
        end
    end

    assign s.awready = aw_rdy;
    assign s.wready  = w_rdy;
    assign s.arready = ar_rdy;
    assign s.bvalid  = (state_q == WR_RESP);
    assign s.bresp   = bresp_q;
    assign s.rvalid  = (state_q == RD_RESP);
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;

    assign reg_addr  = addr_q;
    assign reg_wr    = wr_stb_q;
    assign reg_rd    = rd_stb_q;
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;

endmodule
